pe_weight_loader: RTL and testbench

//  Unpacks the weight-buffer byte stream into per-kernel PE weight words (PE_weight_t layout) for the PE matrix.

---
 rtl/pe_weight_loader.sv | 179 +++++++++++++++++
 tb/tb_pe_weight_loader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_weight_loader.sv
// Unpacks a weight-buffer word stream into one NSLOT-slot kernel word per kernel (PE_weight_t layout).
// Optional feature macro: WT_LOADER_CHECKSUM_EN (running 16-bit sum of accepted words on checksum).
module pe_weight_loader #(
  parameter int WT_WIDTH = 8,
  parameter int KCNT_W   = 10,
  parameter int NSLOT    = 25
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      kernel_mode,
  input  logic                      bit_mode,
  input  logic [KCNT_W-1:0]         num_kernels,
  input  logic [WT_WIDTH-1:0]       in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NSLOT*WT_WIDTH-1:0] out_weight,
  output logic [KCNT_W-1:0]         out_kidx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               checksum
);

  localparam int HALF = WT_WIDTH / 2;
  localparam int PW   = $clog2(NSLOT + 2);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT, S_DONE} state_t;

  state_t              r_state;
  logic                r_kmode;
  logic                r_bmode;
  logic [KCNT_W-1:0]   r_nk;
  logic [KCNT_W-1:0]   r_kidx;
  logic [PW-1:0]       r_wptr;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_done;

  logic [PW-1:0]       w_k;
  logic [PW-1:0]       w_step;
  logic [PW:0]         w_fill_end;
  logic                w_last;
  logic                w_accept;
  logic                w_start_ok;
  logic                w_clear;
  logic [WT_WIDTH-1:0] w_lo;
  logic [WT_WIDTH-1:0] w_hi;

  assign w_k        = r_kmode ? PW'(25) : PW'(9);
  assign w_step     = r_bmode ? PW'(2) : PW'(1);
  assign w_fill_end = {1'b0, r_wptr} + {1'b0, w_step};
  assign w_last     = (w_fill_end >= {1'b0, w_k});
  assign w_accept   = r_in_ready & in_valid;
  assign w_start_ok = (r_state == S_IDLE) & start;
  // Slots restart from zero for every kernel so unused 3*3 slots always read 0.
  assign w_clear    = w_start_ok | (r_out_valid & out_ready);

  assign w_lo = r_bmode ? {{(WT_WIDTH-HALF){in_data[HALF-1]}}, in_data[HALF-1:0]} : in_data;
  assign w_hi = {{(WT_WIDTH-HALF){in_data[WT_WIDTH-1]}}, in_data[WT_WIDTH-1:HALF]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_kmode     <= 1'b0;
      r_bmode     <= 1'b0;
      r_nk        <= '0;
      r_kidx      <= '0;
      r_wptr      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_kmode <= kernel_mode;
            r_bmode <= bit_mode;
            r_nk    <= num_kernels;
            r_kidx  <= '0;
            r_wptr  <= '0;
            r_busy  <= 1'b1;
            if (num_kernels != '0) begin
              r_state    <= S_FILL;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_accept) begin
            if (w_last) begin
              r_wptr      <= '0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_EMIT;
            end else begin
              r_wptr <= r_wptr + w_step;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_kidx == r_nk - 1'b1) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_kidx     <= r_kidx + 1'b1;
              r_in_ready <= 1'b1;
              r_state    <= S_FILL;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Each slot lands at its PE_weight_t field position: A_9 on top, then B_6, C_6, D_4.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      localparam int OFF = (gi < 9)  ? (gi + 16) :
                           (gi < 15) ? (gi + 1)  :
                           (gi < 21) ? (gi - 11) : (gi - 21);
      logic [WT_WIDTH-1:0] r_slot;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_slot <= '0;
        end else if (w_clear) begin
          r_slot <= '0;
        end else if (w_accept && (r_wptr == PW'(gi))) begin
          r_slot <= w_lo;
        end else if (w_accept && r_bmode && ((r_wptr + PW'(1)) == PW'(gi)) && (PW'(gi) < w_k)) begin
          r_slot <= w_hi;
        end
      end

      assign out_weight[OFF*WT_WIDTH +: WT_WIDTH] = r_slot;
    end
  endgenerate

`ifdef WT_LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_checksum <= 16'd0;
    end else if (w_start_ok) begin
      r_checksum <= 16'd0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + 16'(in_data);
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 16'd0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_kidx  = r_kidx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_pe_weight_loader.sv
// Self-checking bench for pe_weight_loader: directed cases plus randomized runs against a flat slot-list model.
module tb_pe_weight_loader;
  localparam int W  = 8;
  localparam int KW = 10;
  localparam int NS = 25;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             kernel_mode = 1'b0;
  logic             bit_mode = 1'b0;
  logic [KW-1:0]    num_kernels = '0;
  logic [W-1:0]     in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NS*W-1:0]  out_weight;
  logic [KW-1:0]    out_kidx;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             done;
  logic [15:0]      checksum;

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  int ov_count = 0;
  logic [W-1:0] kw [0:24];
  logic [15:0]  exp_sum = 16'd0;

  pe_weight_loader #(.WT_WIDTH(W), .KCNT_W(KW), .NSLOT(NS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_mode(kernel_mode), .bit_mode(bit_mode),
    .num_kernels(num_kernels), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_weight(out_weight), .out_kidx(out_kidx), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_count++;
    if (out_valid) ov_count++;
  end

  function automatic logic [7:0] sx(input logic [3:0] n);
    return {{4{n[3]}}, n};
  endfunction

  task automatic do_start(input logic km, input logic bm, input int nk);
    start = 1'b1; kernel_mode = km; bit_mode = bm; num_kernels = KW'(nk);
    @(negedge clk);
    start = 1'b0; kernel_mode = 1'($urandom); bit_mode = 1'($urandom); num_kernels = KW'($urandom);
    exp_sum = 16'd0;
  endtask

  // Feeds one kernel's beats from kw[], then checks the emitted word; optional gaps and output stall.
  task automatic run_kernel(input logic km, input logic bm, input int kidx, input int gap_pct,
                            input int hold, input string tag);
    int k, nb, tries;
    logic rdy;
    logic [7:0] s[$];
    logic [7:0] slot [0:24];
    logic [71:0] fa;
    logic [47:0] fb, fc;
    logic [31:0] fd;
    logic [NS*W-1:0] exp_w, held;
    k = km ? 25 : 9;
    nb = bm ? (k + 1) / 2 : k;
    for (int b = 0; b < nb; b++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0; in_data = W'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = kw[b];
      tries = 0;
      do begin
        rdy = in_ready;
        @(posedge clk);
        @(negedge clk);
        tries++;
      end while (!rdy && tries < 20);
      if (!rdy) begin
        checks++; failures++;
        $display("FAIL %s beat_accept: beat %0d in_ready=0 for 20 cycles, required 1", tag, b);
        in_valid = 1'b0;
        return;
      end
      exp_sum = exp_sum + 16'(kw[b]);
    end
    in_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (!bm) s.push_back(kw[b]);
      else begin
        s.push_back(sx(kw[b][3:0]));
        s.push_back(sx(kw[b][7:4]));
      end
    end
    for (int i = 0; i < 25; i++) slot[i] = (i < k) ? s[i] : 8'h00;
    for (int i = 0; i < 9; i++) fa[i*8 +: 8] = slot[i];
    for (int i = 0; i < 6; i++) fb[i*8 +: 8] = slot[9 + i];
    for (int i = 0; i < 6; i++) fc[i*8 +: 8] = slot[15 + i];
    for (int i = 0; i < 4; i++) fd[i*8 +: 8] = slot[21 + i];
    exp_w = {fa, fb, fc, fd};
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s out_valid_latency: got %b, required 1", tag, out_valid);
    end
    checks++;
    if (out_weight !== exp_w) begin
      failures++;
      $display("FAIL %s out_weight k%0d: got %h, required %h", tag, kidx, out_weight, exp_w);
    end
    checks++;
    if (out_kidx !== KW'(kidx)) begin
      failures++;
      $display("FAIL %s out_kidx: got %0d, required %0d", tag, out_kidx, kidx);
    end
    held = exp_w;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_data = W'($urandom); out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_weight} !== {1'b1, 1'b0, held}) begin
        failures++;
        $display("FAIL %s stall_hold c%0d: got v=%b r=%b w=%h, required v=1 r=0 w=%h",
                 tag, h, out_valid, in_ready, out_weight, held);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("kernel %s k%0d km=%0d bm=%0d gap=%0d hold=%0d done", tag, kidx, km, bm, gap_pct, hold);
  endtask

  task automatic finish_run(input int dc0, input string tag);
    logic [15:0] exp_cs;
    for (int i = 0; i < 6 && done_count == dc0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_count != dc0 + 1) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d, required 1", tag, done_count - dc0);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after_done: got %b, required 0", tag, busy);
    end
`ifdef WT_LOADER_CHECKSUM_EN
    exp_cs = exp_sum;
`else
    exp_cs = 16'd0;
`endif
    checks++;
    if (checksum !== exp_cs) begin
      failures++;
      $display("FAIL %s checksum: got %h, required %h", tag, checksum, exp_cs);
    end
    $display("run %s finished checksum=%h", tag, checksum);
  endtask

  task automatic fill_random;
    for (int i = 0; i < 25; i++) kw[i] = W'($urandom);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_weight, out_kidx, out_valid, in_ready, busy, done, checksum} !== '0) begin
      failures++;
      $display("FAIL reset_state: got w=%h k=%0d v=%b r=%b b=%b d=%b cs=%h, required all 0",
               out_weight, out_kidx, out_valid, in_ready, busy, done, checksum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_8b_3x3;
    int dc0 = done_count;
    do_start(1'b0, 1'b0, 2);
    for (int i = 0; i < 9; i++) kw[i] = W'(i + 1);
    run_kernel(1'b0, 1'b0, 0, 0, 0, "t1");
    for (int i = 0; i < 9; i++) kw[i] = W'(i + 10);
    run_kernel(1'b0, 1'b0, 1, 0, 0, "t1");
    finish_run(dc0, "t1");
  endtask

  task automatic test_4b_5x5;
    int dc0 = done_count;
    logic [7:0] t2 [0:12];
    t2 = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F, 8'h21, 8'h43, 8'h65, 8'h87, 8'hF7};
    for (int i = 0; i < 13; i++) kw[i] = t2[i];
    do_start(1'b1, 1'b1, 1);
    run_kernel(1'b1, 1'b1, 0, 0, 0, "t2");
    finish_run(dc0, "t2");
  endtask

  task automatic test_backpressure;
    int dc0;
    logic [7:0] save [0:24];
    fill_random();
    for (int i = 0; i < 25; i++) save[i] = kw[i];
    dc0 = done_count;
    do_start(1'b1, 1'b0, 1);
    run_kernel(1'b1, 1'b0, 0, 0, 10, "t3_gapless");
    finish_run(dc0, "t3_gapless");
    for (int i = 0; i < 25; i++) kw[i] = save[i];
    dc0 = done_count;
    do_start(1'b1, 1'b0, 1);
    run_kernel(1'b1, 1'b0, 0, 40, 3, "t3_gaps");
    finish_run(dc0, "t3_gaps");
  endtask

  task automatic test_zero_kernels;
    int dc0 = done_count;
    int oc0 = ov_count;
    do_start(1'b0, 1'b0, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (done_count != dc0 + 1 || ov_count != oc0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_kernels: got done=%0d outv=%0d busy=%b, required done=1 outv=0 busy=0",
               done_count - dc0, ov_count - oc0, busy);
    end
    $display("test_zero_kernels done");
  endtask

  task automatic test_start_during_run;
    int dc0 = done_count;
    do_start(1'b0, 1'b0, 2);
    start = 1'b1; kernel_mode = 1'b1; bit_mode = 1'b1; num_kernels = KW'(7);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL start_ignored: got busy=%b in_ready=%b, required 1 1", busy, in_ready);
    end
    fill_random();
    run_kernel(1'b0, 1'b0, 0, 20, 0, "t4_start");
    fill_random();
    run_kernel(1'b0, 1'b0, 1, 20, 1, "t4_start");
    finish_run(dc0, "t4_start");
  endtask

  task automatic test_reset_midfill;
    int dc0;
    do_start(1'b1, 1'b1, 3);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = W'($urandom);
      @(negedge clk);
    end
    dc0 = done_count;
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_weight, out_kidx, out_valid, in_ready, busy, done, checksum} !== '0) begin
      failures++;
      $display("FAIL reset_midfill: got w=%h k=%0d v=%b r=%b b=%b d=%b cs=%h, required all 0",
               out_weight, out_kidx, out_valid, in_ready, busy, done, checksum);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_count != dc0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d done pulses, required 0", done_count - dc0);
    end
    dc0 = done_count;
    fill_random();
    do_start(1'b1, 1'b1, 1);
    run_kernel(1'b1, 1'b1, 0, 0, 0, "t4_rst");
    finish_run(dc0, "t4_rst");
  endtask

  task automatic test_checksum;
    int dc0 = done_count;
    logic [15:0] exp_cs;
    for (int i = 0; i < 9; i++) kw[i] = 8'hFF;
    do_start(1'b0, 1'b0, 1);
    run_kernel(1'b0, 1'b0, 0, 0, 0, "t5");
    finish_run(dc0, "t5");
`ifdef WT_LOADER_CHECKSUM_EN
    exp_cs = 16'h08F7;
`else
    exp_cs = 16'h0000;
`endif
    checks++;
    if (checksum !== exp_cs) begin
      failures++;
      $display("FAIL checksum_ff: got %h, required %h", checksum, exp_cs);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      int dc0 = done_count;
      logic km = 1'($urandom);
      logic bm = 1'($urandom);
      int nk = $urandom_range(3, 1);
      do_start(km, bm, nk);
      for (int k = 0; k < nk; k++) begin
        fill_random();
        run_kernel(km, bm, k, $urandom_range(50), $urandom_range(3), "rand");
      end
      finish_run(dc0, "rand");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_8b_3x3();
    test_4b_5x5();
    test_backpressure();
    test_zero_kernels();
    test_start_during_run();
    test_reset_midfill();
    test_checksum();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
